// File: rtl/tlb_op_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : tlb_op_ctrl_if
// Description : Command/response bus between the EXE/CSR side and the TLB
//               maintenance-op controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface tlb_op_ctrl_if #(
   parameter int TLBNUM = 16
);
   localparam int IDXW = $clog2(TLBNUM);

   logic            cmd_valid;
   logic            cmd_ready;
   logic [2:0]      cmd_op;
   logic [4:0]      cmd_inv_op;
   logic [9:0]      cmd_asid;
   logic [18:0]     cmd_vppn;
   logic [IDXW-1:0] cmd_index;
   logic [88:0]     cmd_entry;

   logic            rsp_valid;
   logic [2:0]      rsp_op;
   logic            rsp_found;
   logic [IDXW-1:0] rsp_index;
   logic [88:0]     rsp_entry;
   logic            rsp_err;

   // Requester side: issues commands, consumes responses
   modport master (
      output cmd_valid, cmd_op, cmd_inv_op, cmd_asid, cmd_vppn, cmd_index, cmd_entry,
      input  cmd_ready,
      input  rsp_valid, rsp_op, rsp_found, rsp_index, rsp_entry, rsp_err
   );

   // Controller side
   modport slave (
      input  cmd_valid, cmd_op, cmd_inv_op, cmd_asid, cmd_vppn, cmd_index, cmd_entry,
      output cmd_ready,
      output rsp_valid, rsp_op, rsp_found, rsp_index, rsp_entry, rsp_err
   );
endinterface
`default_nettype wire

// File: rtl/tlb_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tlb_op_ctrl
// Description : Sequences TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB onto the TLB
//               search-1, read, write and invalidate ports, shares search
//               port 1 with the LSU (LSU wins), generates the pseudo-random
//               fill index and returns a one-cycle response to the CSR unit.
//               Optional build macro TLB_FILL_PREFER_INVALID_EN: FILL picks
//               the lowest invalid entry before falling back to the LFSR.
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_op_ctrl #(
   parameter int TLBNUM = 16
) (
   input  logic                           clk,
   input  logic                           rstn,
   tlb_op_ctrl_if.slave                   bus,
   input  logic                           lsu_hold,
   output logic                           ctl_s1_sel,
   output logic [18:0]                    ctl_s1_vppn,
   output logic [9:0]                     ctl_s1_asid,
   input  logic                           s1_found,
   input  logic [$clog2(TLBNUM)-1:0]      s1_index,
   output logic [$clog2(TLBNUM)-1:0]      tlb_r_index,
   input  logic [88:0]                    tlb_r_entry,
   output logic                           tlb_we,
   output logic [$clog2(TLBNUM)-1:0]      tlb_w_index,
   output logic [88:0]                    tlb_w_entry,
   output logic                           tlb_inv_valid,
   output logic [4:0]                     tlb_inv_op,
   input  logic [TLBNUM-1:0]              tlb_e_vec
);
   localparam int IDXW = $clog2(TLBNUM);

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_EXEC = 2'd1;
   localparam logic [1:0] c_ST_RESP = 2'd2;

   localparam logic [2:0] c_OP_SRCH = 3'd0;
   localparam logic [2:0] c_OP_RD   = 3'd1;
   localparam logic [2:0] c_OP_WR   = 3'd2;
   localparam logic [2:0] c_OP_FILL = 3'd3;
   localparam logic [2:0] c_OP_INV  = 3'd4;

   localparam logic [4:0] c_INV_OP_MAX = 5'd6;

   logic [1:0]      r_state;
   logic [7:0]      r_lfsr;
   logic [2:0]      r_op;
   logic [4:0]      r_inv_op;
   logic [9:0]      r_asid;
   logic [18:0]     r_vppn;
   logic [IDXW-1:0] r_index;
   logic [IDXW-1:0] r_w_index;
   logic [88:0]     r_entry;

   logic [2:0]      r_rsp_op;
   logic            r_rsp_found;
   logic [IDXW-1:0] r_rsp_index;
   logic [88:0]     r_rsp_entry;
   logic            r_rsp_err;

   logic            w_accept;
   logic            w_exec;
   logic            w_lfsr_fb;
   logic            w_op_rsvd;
   logic            w_inv_bad;
   logic [IDXW-1:0] w_fill_idx;

   assign bus.cmd_ready = (r_state == c_ST_IDLE) & ~lsu_hold;
   assign w_accept      = bus.cmd_valid & bus.cmd_ready;
   assign w_exec        = (r_state == c_ST_EXEC);
   assign w_lfsr_fb     = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
   assign w_op_rsvd     = (r_op > c_OP_INV);
   assign w_inv_bad     = (r_inv_op > c_INV_OP_MAX);

`ifdef TLB_FILL_PREFER_INVALID_EN
   logic            w_free_found;
   logic [IDXW-1:0] w_free_idx;

   // Lowest entry whose E bit is clear; the scan runs downward so the lowest wins
   always_comb begin
      w_free_found = 1'b0;
      w_free_idx   = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (!tlb_e_vec[i]) begin
            w_free_found = 1'b1;
            w_free_idx   = IDXW'(i);
         end
      end
   end

   assign w_fill_idx = w_free_found ? w_free_idx : r_lfsr[IDXW-1:0];
`else
   logic w_unused_e_vec;

   // E bits only matter for invalid-first fill selection
   assign w_unused_e_vec = ^tlb_e_vec;
   assign w_fill_idx     = r_lfsr[IDXW-1:0];
`endif

   // Free-running maximal-length LFSR; seeded non-zero so it never locks up
   always_ff @(posedge clk) begin
      if (!rstn) r_lfsr <= 8'h01;
      else       r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
   end

   // Three-phase sequencer: accept -> drive TLB ports -> respond
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= c_ST_IDLE;
      end else begin
         case (r_state)
            c_ST_IDLE: if (w_accept) r_state <= c_ST_EXEC;
            c_ST_EXEC: r_state <= c_ST_RESP;
            c_ST_RESP: r_state <= c_ST_IDLE;
            default:   r_state <= c_ST_IDLE;
         endcase
      end
   end

   // Capture the command on accept; FILL resolves its target index right here
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_op      <= '0;
         r_inv_op  <= '0;
         r_asid    <= '0;
         r_vppn    <= '0;
         r_index   <= '0;
         r_w_index <= '0;
         r_entry   <= '0;
      end else if (w_accept) begin
         r_op      <= bus.cmd_op;
         r_inv_op  <= bus.cmd_inv_op;
         r_asid    <= bus.cmd_asid;
         r_vppn    <= bus.cmd_vppn;
         r_index   <= bus.cmd_index;
         r_w_index <= (bus.cmd_op == c_OP_FILL) ? w_fill_idx : bus.cmd_index;
         r_entry   <= bus.cmd_entry;
      end
   end

   // Register TLB results at the end of EXEC so the response is stable in RESP
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_rsp_op    <= '0;
         r_rsp_found <= 1'b0;
         r_rsp_index <= '0;
         r_rsp_entry <= '0;
         r_rsp_err   <= 1'b0;
      end else if (w_exec) begin
         r_rsp_op    <= r_op;
         r_rsp_found <= 1'b0;
         r_rsp_index <= '0;
         r_rsp_entry <= '0;
         r_rsp_err   <= w_op_rsvd | ((r_op == c_OP_INV) & w_inv_bad);
         case (r_op)
            c_OP_SRCH: begin
               r_rsp_found <= s1_found;
               r_rsp_index <= s1_found ? s1_index : '0;
            end
            // An invalid entry reads back as all-zero (its E bit is already 0)
            c_OP_RD:   r_rsp_entry <= tlb_r_entry[88] ? tlb_r_entry : '0;
            c_OP_FILL: r_rsp_index <= r_w_index;
            default:   r_rsp_index <= '0;
         endcase
      end
   end

   // Port strobes decode only from registered state, so they are clean and EXEC-only
   assign ctl_s1_sel    = w_exec & ((r_op == c_OP_SRCH) | (r_op == c_OP_INV));
   assign ctl_s1_vppn   = r_vppn;
   assign ctl_s1_asid   = r_asid;
   assign tlb_r_index   = r_index;
   assign tlb_we        = w_exec & ((r_op == c_OP_WR) | (r_op == c_OP_FILL));
   assign tlb_w_index   = r_w_index;
   assign tlb_w_entry   = r_entry;
   assign tlb_inv_valid = w_exec & (r_op == c_OP_INV) & ~w_inv_bad;
   assign tlb_inv_op    = r_inv_op;

   assign bus.rsp_valid = (r_state == c_ST_RESP);
   assign bus.rsp_op    = r_rsp_op;
   assign bus.rsp_found = r_rsp_found;
   assign bus.rsp_index = r_rsp_index;
   assign bus.rsp_entry = r_rsp_entry;
   assign bus.rsp_err   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_tlb_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlb_op_ctrl
// Description : Scoreboard bench for tlb_op_ctrl with a behavioural TLB and a
//               reference model of the controller's responses and port use.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlb_op_ctrl;
   localparam int TLBNUM = 16;
   localparam int IDXW   = $clog2(TLBNUM);

   localparam logic [2:0] OP_SRCH = 3'd0;
   localparam logic [2:0] OP_RD   = 3'd1;
   localparam logic [2:0] OP_WR   = 3'd2;
   localparam logic [2:0] OP_FILL = 3'd3;
   localparam logic [2:0] OP_INV  = 3'd4;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   logic lsu_hold = 1'b0;

   logic            ctl_s1_sel;
   logic [18:0]     ctl_s1_vppn;
   logic [9:0]      ctl_s1_asid;
   logic            s1_found;
   logic [IDXW-1:0] s1_index;
   logic [IDXW-1:0] tlb_r_index;
   logic [88:0]     tlb_r_entry;
   logic            tlb_we;
   logic [IDXW-1:0] tlb_w_index;
   logic [88:0]     tlb_w_entry;
   logic            tlb_inv_valid;
   logic [4:0]      tlb_inv_op;
   logic [TLBNUM-1:0] tlb_e_vec = '1;

   tlb_op_ctrl_if #(.TLBNUM(TLBNUM)) bus ();

   tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
      .clk(clk), .rstn(rstn), .bus(bus), .lsu_hold(lsu_hold),
      .ctl_s1_sel(ctl_s1_sel), .ctl_s1_vppn(ctl_s1_vppn), .ctl_s1_asid(ctl_s1_asid),
      .s1_found(s1_found), .s1_index(s1_index),
      .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry),
      .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_entry(tlb_w_entry),
      .tlb_inv_valid(tlb_inv_valid), .tlb_inv_op(tlb_inv_op), .tlb_e_vec(tlb_e_vec)
   );

   always #5 clk = ~clk;

   // Entry field helpers: {e,vppn,ps,asid,g,...}
   function automatic logic tlb_match(input logic [88:0] e, input logic [18:0] vppn, input logic [9:0] asid);
      return e[88] && (e[87:69] == vppn) && (e[52] || (e[62:53] == asid));
   endfunction

   function automatic logic [88:0] mk_entry(input logic e, input logic [18:0] vppn,
                                            input logic [9:0] asid, input logic g, input logic [51:0] rest);
      return {e, vppn, 6'd12, asid, g, rest};
   endfunction

   // Fill-index LFSR state n cycles after reset release
   function automatic logic [7:0] lfsr_nth(input int n);
      logic [7:0] s = 8'h01;
      for (int k = 0; k < n; k++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
      return s;
   endfunction

   // Behavioural TLB that the DUT drives
   logic [88:0] hw_tlb [TLBNUM];
   always @(posedge clk) begin
      if (!rstn) for (int i = 0; i < TLBNUM; i++) hw_tlb[i] <= '0;
      else if (tlb_we) hw_tlb[tlb_w_index] <= tlb_w_entry;
   end

   always_comb begin
      s1_found = 1'b0;
      s1_index = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (tlb_match(hw_tlb[i], ctl_s1_vppn, ctl_s1_asid)) begin
            s1_found = 1'b1;
            s1_index = IDXW'(i);
         end
      end
   end
   assign tlb_r_entry = hw_tlb[tlb_r_index];

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [2:0] op; logic found; logic [IDXW-1:0] index; logic [88:0] entry; logic err; int cyc;
   } rsp_t;
   typedef struct {
      logic we; logic [IDXW-1:0] widx; logic [88:0] wentry; logic inv; logic [4:0] inv_op;
      logic sel; logic [18:0] vppn; logic [9:0] asid; int cyc;
   } port_t;

   rsp_t  rsp_q  [$];
   port_t port_q [$];
   logic [88:0] ref_tlb [TLBNUM];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   int   cyc = 0;
   int   acc_cyc = -100;
   int   lfsr_n = 0;
   logic prev_rstn = 1'b0;
   rsp_t  mr;
   port_t mp;
   logic [7:0] lv;
   logic [IDXW-1:0] fi;

   // Monitor: sample everything on the falling edge
   always @(negedge clk) begin
      cyc++;
      if (!prev_rstn) lfsr_n = 0; else lfsr_n++;

      if (!prev_rstn) begin
         chk("reset_strobes", 128'({bus.rsp_valid, tlb_we, tlb_inv_valid, ctl_s1_sel}), 128'(0));
         chk("reset_rsp", 128'({bus.rsp_err, bus.rsp_found, bus.rsp_index, bus.rsp_entry}), 128'(0));
      end

      chk("cmd_ready", 128'(bus.cmd_ready), 128'(((cyc - acc_cyc) >= 3) && !lsu_hold));

      if (tlb_we || tlb_inv_valid || ctl_s1_sel) begin
         if (port_q.size() == 0) begin
            chk("port_unexpected", 128'({tlb_we, tlb_inv_valid, ctl_s1_sel}), 128'(0));
         end else begin
            mp = port_q.pop_front();
            chk("port_latency", 128'(cyc - mp.cyc), 128'(1));
            chk("port_flags", 128'({tlb_we, tlb_inv_valid, ctl_s1_sel}), 128'({mp.we, mp.inv, mp.sel}));
            if (mp.we) begin
               chk("w_index", 128'(tlb_w_index), 128'(mp.widx));
               chk("w_entry", 128'(tlb_w_entry), 128'(mp.wentry));
            end
            if (mp.inv) chk("inv_op", 128'(tlb_inv_op), 128'(mp.inv_op));
            if (mp.sel) chk("s1_key", 128'({ctl_s1_vppn, ctl_s1_asid}), 128'({mp.vppn, mp.asid}));
         end
      end
      if (port_q.size() != 0 && (cyc - port_q[0].cyc) > 1) begin
         mp = port_q.pop_front();
         chk("port_missing", 128'({tlb_we, tlb_inv_valid, ctl_s1_sel}), 128'({mp.we, mp.inv, mp.sel}));
      end

      if (bus.rsp_valid) begin
         if (rsp_q.size() == 0) begin
            chk("rsp_unexpected", 128'(bus.rsp_valid), 128'(0));
         end else begin
            mr = rsp_q.pop_front();
            chk("rsp_latency", 128'(cyc - mr.cyc), 128'(2));
            chk("rsp_op", 128'(bus.rsp_op), 128'(mr.op));
            chk("rsp_err", 128'(bus.rsp_err), 128'(mr.err));
            if (mr.op == OP_SRCH) chk("rsp_srch", 128'({bus.rsp_found, bus.rsp_index}), 128'({mr.found, mr.index}));
            if (mr.op == OP_FILL) chk("rsp_fill_index", 128'(bus.rsp_index), 128'(mr.index));
            if (mr.op == OP_RD)   chk("rsp_entry", 128'(bus.rsp_entry), 128'(mr.entry));
         end
      end
      if (rsp_q.size() != 0 && (cyc - rsp_q[0].cyc) > 2) begin
         mr = rsp_q.pop_front();
         chk("rsp_missing", 128'(bus.rsp_valid), 128'(1));
      end

      // Reference model: expected outcome decided at the moment of acceptance
      if (bus.cmd_valid && bus.cmd_ready && rstn) begin
         acc_cyc = cyc;
         mr = '{op: bus.cmd_op, found: 1'b0, index: '0, entry: '0, err: 1'b0, cyc: cyc};
         mp = '{we: 1'b0, widx: '0, wentry: '0, inv: 1'b0, inv_op: '0, sel: 1'b0,
                vppn: bus.cmd_vppn, asid: bus.cmd_asid, cyc: cyc};
         case (bus.cmd_op)
            OP_SRCH: begin
               for (int i = TLBNUM - 1; i >= 0; i--)
                  if (tlb_match(ref_tlb[i], bus.cmd_vppn, bus.cmd_asid)) begin
                     mr.found = 1'b1; mr.index = IDXW'(i);
                  end
               mp.sel = 1'b1;
               port_q.push_back(mp);
            end
            OP_RD: mr.entry = ref_tlb[bus.cmd_index][88] ? ref_tlb[bus.cmd_index] : '0;
            OP_WR: begin
               ref_tlb[bus.cmd_index] = bus.cmd_entry;
               mp.we = 1'b1; mp.widx = bus.cmd_index; mp.wentry = bus.cmd_entry;
               port_q.push_back(mp);
            end
            OP_FILL: begin
               lv = lfsr_nth(lfsr_n);
               fi = lv[IDXW-1:0];
`ifdef TLB_FILL_PREFER_INVALID_EN
               for (int i = TLBNUM - 1; i >= 0; i--) if (!tlb_e_vec[i]) fi = IDXW'(i);
`endif
               ref_tlb[fi] = bus.cmd_entry;
               mr.index = fi;
               mp.we = 1'b1; mp.widx = fi; mp.wentry = bus.cmd_entry;
               port_q.push_back(mp);
            end
            OP_INV: begin
               mp.sel = 1'b1;
               if (bus.cmd_inv_op <= 5'd6) begin
                  mp.inv = 1'b1; mp.inv_op = bus.cmd_inv_op;
               end else begin
                  mr.err = 1'b1;
               end
               port_q.push_back(mp);
            end
            default: mr.err = 1'b1;
         endcase
         rsp_q.push_back(mr);
      end

      // Reset seen by the next edge drops everything in flight
      if (!rstn) begin
         rsp_q.delete();
         port_q.delete();
         acc_cyc = -100;
         for (int i = 0; i < TLBNUM; i++) ref_tlb[i] = '0;
      end
      prev_rstn = rstn;
   end

   // ---------------- stimulus ----------------
   task automatic issue(input logic [2:0] op, input logic [4:0] inv_op, input logic [9:0] asid,
                        input logic [18:0] vppn, input logic [IDXW-1:0] idx, input logic [88:0] entry);
      int n = 0;
      bus.cmd_valid  = 1'b1;
      bus.cmd_op     = op;
      bus.cmd_inv_op = inv_op;
      bus.cmd_asid   = asid;
      bus.cmd_vppn   = vppn;
      bus.cmd_index  = idx;
      bus.cmd_entry  = entry;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.cmd_ready && n < 200);
      if (!bus.cmd_ready) begin
         checks++; errors++;
         $display("FAIL accept_timeout: cmd_ready stayed %0b, required 1", bus.cmd_ready);
      end
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   logic [95:0] rnd;
   logic [18:0] vsel [4] = '{19'h00123, 19'h00456, 19'h00007, 19'h7ABCD};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_inv_op = '0; bus.cmd_asid = '0;
      bus.cmd_vppn = '0; bus.cmd_index = '0; bus.cmd_entry = '0;
      repeat (4) @(posedge clk);
      #1 rstn = 1'b1;
      idle_cycles(2);

      // Write, search hit, search miss (wrong ASID, g=0)
      issue(OP_WR, 5'd0, 10'h005, 19'h0, 4'd3, mk_entry(1'b1, 19'h00123, 10'h005, 1'b0, 52'hABCDE_12345_678));
      issue(OP_SRCH, 5'd0, 10'h005, 19'h00123, 4'd0, '0);
      issue(OP_SRCH, 5'd0, 10'h006, 19'h00123, 4'd0, '0);
      // Read back a valid entry, then an entry written with e=0
      issue(OP_RD, 5'd0, 10'h0, 19'h0, 4'd3, '0);
      issue(OP_WR, 5'd0, 10'h0, 19'h0, 4'd5, mk_entry(1'b0, 19'h55555, 10'h3FF, 1'b1, 52'hFFFFF_FFFFF_FFF));
      issue(OP_RD, 5'd0, 10'h0, 19'h0, 4'd5, '0);

      // LSU holds search port 1 for 5 cycles while a command waits
      idle_cycles(3);
      lsu_hold = 1'b1;
      bus.cmd_valid = 1'b1; bus.cmd_op = OP_SRCH;
      idle_cycles(5);
      lsu_hold = 1'b0;
      issue(OP_SRCH, 5'd0, 10'h005, 19'h00123, 4'd0, '0);

      // Invalidate: legal op, then op 7 (error, no pulse)
      issue(OP_INV, 5'd5, 10'h005, 19'h00123, 4'd0, '0);
      issue(OP_INV, 5'd7, 10'h005, 19'h00123, 4'd0, '0);
      // Reserved opcodes
      issue(3'd5, 5'd0, 10'h0, 19'h0, 4'd0, '0);
      issue(3'd7, 5'd0, 10'h0, 19'h0, 4'd0, '0);

      // Consecutive fills, first with entry 3 free
      tlb_e_vec = 16'hFFF7;
      for (int k = 0; k < 6; k++)
         issue(OP_FILL, 5'd0, 10'h0, 19'h0, 4'd0, mk_entry(1'b1, 19'h01000 + 19'(k), 10'h001, 1'b0, 52'(k)));
      tlb_e_vec = '1;
      idle_cycles(3);

      // Randomised traffic with occasional LSU holds between commands
      for (int k = 0; k < 250; k++) begin
         rnd = {$urandom, $urandom, $urandom};
         if ($urandom_range(0, 3) == 0) begin
            idle_cycles(2);
            lsu_hold = 1'b1;
            idle_cycles($urandom_range(1, 3));
            lsu_hold = 1'b0;
         end
         tlb_e_vec = ($urandom_range(0, 3) == 0) ? '1 : TLBNUM'($urandom);
         issue(3'($urandom_range(0, 7)), 5'($urandom_range(0, 8)), 10'($urandom_range(0, 3)),
               vsel[$urandom_range(0, 3)], IDXW'($urandom),
               mk_entry(($urandom_range(0, 5) != 0), vsel[$urandom_range(0, 3)],
                        10'($urandom_range(0, 3)), rnd[95], rnd[51:0]));
      end
      idle_cycles(4);

      // Reset asserted while a write is in EXEC
      issue(OP_WR, 5'd0, 10'h0, 19'h0, 4'd9, mk_entry(1'b1, 19'h00999, 10'h002, 1'b1, 52'h1));
      rstn = 1'b0;
      idle_cycles(1);
      rstn = 1'b1;
      idle_cycles(2);
      issue(OP_RD, 5'd0, 10'h0, 19'h0, 4'd9, '0);
      issue(OP_FILL, 5'd0, 10'h0, 19'h0, 4'd0, mk_entry(1'b1, 19'h00AAA, 10'h001, 1'b0, 52'h2));
      idle_cycles(6);

      chk("rsp_queue_drained", 128'(rsp_q.size()), 128'(0));
      chk("port_queue_drained", 128'(port_q.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
